// File: rtl/regfile_dump_engine_pkg.sv
// Shared types and constants for the register-file dump engine: widths, FSM
// state encoding and the buffered {index, data} entry.
package regfile_dbg_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
    } dump_entry_t;

    // Number of words in an inclusive, wrapping range: 1..32.
    function automatic logic [ADDR_W:0] range_len(input logic [ADDR_W-1:0] first,
                                                  input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] diff;
        diff = last - first;
        return {1'b0, diff} + (ADDR_W+1)'(1);
    endfunction

endpackage

// File: rtl/regfile_dump_engine_if.sv
// Register-file read ports plus the valid/ready word stream of the dump engine.
interface regfile_dump_engine_if;
    import regfile_dbg_pkg::*;

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;

    modport master (
        output rd_addr1, rd_addr2, out_valid, out_data, out_index,
        input  rd_data1, rd_data2, out_ready
    );

    modport slave (
        input  rd_addr1, rd_addr2, out_valid, out_data, out_index,
        output rd_data1, rd_data2, out_ready
    );

endinterface

// File: rtl/regfile_dump_engine_fifo2.sv
// Two-entry in-order output buffer. Pushes only land in an empty buffer, so
// push and pop are never requested in the same cycle.
module dump_fifo2
    import regfile_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push1_i,
    input  logic        push2_i,
    input  logic        pop_i,
    input  dump_entry_t entry0_i,
    input  dump_entry_t entry1_i,
    output dump_entry_t head_o,
    output logic [1:0]  count_o,
    output logic        valid_o
);

    dump_entry_t mem0_q, mem0_d;
    dump_entry_t mem1_q, mem1_d;
    logic [1:0]  count_q, count_d;

    // Next-state selection: push has priority, a pop shifts the tail to the head.
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (push2_i && (count_q == 2'd0)) begin
            mem0_d  = entry0_i;
            mem1_d  = entry1_i;
            count_d = 2'd2;
        end else if (push1_i && (count_q != 2'd2)) begin
            if (count_q == 2'd0) begin
                mem0_d = entry0_i;
            end else begin
                mem1_d = entry0_i;
            end
            count_d = count_q + 2'd1;
        end else if (pop_i && (count_q != 2'd0)) begin
            mem0_d  = mem1_q;
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Buffer storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem0_q;
    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/regfile_dump_engine.sv
// Debug dump engine: walks a wrapping register range two words at a time over
// the register file's asynchronous read ports and streams {index, data} out.
module regfile_dump_engine
    import regfile_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_reg_i,
    input  logic [ADDR_W-1:0] last_reg_i,
    output logic              busy_o,
    output logic              wr_block_o,
    output logic              done_o,
    regfile_dump_engine_if.master bus
);

    dump_state_e       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   remain_q;
    logic [ADDR_W-1:0] rd_addr1_q;
    logic [ADDR_W-1:0] rd_addr2_q;
    logic              busy_q;
    logic              done_q;

    dump_entry_t       entry0_s;
    dump_entry_t       entry1_s;
    dump_entry_t       head_s;
    logic [1:0]        count_s;
    logic              valid_s;
    logic              push1_s;
    logic              push2_s;
    logic              pop_s;

    assign pop_s = valid_s & bus.out_ready;

    // Capture both read ports only into an empty buffer; one port for an odd tail.
    always_comb begin
        push1_s  = 1'b0;
        push2_s  = 1'b0;
        entry0_s = '{index: ptr_q, data: bus.rd_data1};
        entry1_s = '{index: ptr_q + ADDR_W'(1), data: bus.rd_data2};
        if ((state_q == READ) && (count_s == 2'd0)) begin
            if (remain_q >= (ADDR_W+1)'(2)) begin
                push2_s = 1'b1;
            end else begin
                push1_s = 1'b1;
            end
        end else begin
            push1_s = 1'b0;
            push2_s = 1'b0;
        end
    end

    // Dump sequencer: range latch, pointer walk, drain and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        ptr_q      <= first_reg_i;
                        remain_q   <= range_len(first_reg_i, last_reg_i);
                        rd_addr1_q <= first_reg_i;
                        rd_addr2_q <= first_reg_i + ADDR_W'(1);
                        busy_q     <= 1'b1;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (push2_s) begin
                        ptr_q      <= ptr_q + ADDR_W'(2);
                        remain_q   <= remain_q - (ADDR_W+1)'(2);
                        rd_addr1_q <= ptr_q + ADDR_W'(2);
                        rd_addr2_q <= ptr_q + ADDR_W'(3);
                        if (remain_q == (ADDR_W+1)'(2)) begin
                            state_q <= DRAIN;
                        end
                    end else if (push1_s) begin
                        remain_q <= '0;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as soon as the final word is being taken, so done follows it directly.
                    if ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dump_fifo2 u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push1_i  (push1_s),
        .push2_i  (push2_s),
        .pop_i    (pop_s),
        .entry0_i (entry0_s),
        .entry1_i (entry1_s),
        .head_o   (head_s),
        .count_o  (count_s),
        .valid_o  (valid_s)
    );

    assign bus.rd_addr1  = rd_addr1_q;
    assign bus.rd_addr2  = rd_addr2_q;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = head_s.data;
    assign bus.out_index = head_s.index;
    assign busy_o        = busy_q;
    assign wr_block_o    = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Self-checking bench: a register-file model feeds the read ports and each
// dump is scored against a list of words computed from the requested range.
module tb_regfile_dump_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_reg = 5'd0;
    logic [4:0]  last_reg = 5'd0;
    logic        busy;
    logic        wr_block;
    logic        done;
    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;

    regfile_dump_engine_if bus ();

    assign bus.rd_data1 = (bus.rd_addr1 == 5'd0) ? 32'd0 : regs[bus.rd_addr1];
    assign bus.rd_data2 = (bus.rd_addr2 == 5'd0) ? 32'd0 : regs[bus.rd_addr2];

    regfile_dump_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .first_reg_i (first_reg),
        .last_reg_i  (last_reg),
        .busy_o      (busy),
        .wr_block_o  (wr_block),
        .done_o      (done),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    // Registers hold 3*i; register 0 is hardwired to zero.
    task automatic fill_regs_linear();
        for (int i = 0; i < 32; i++) regs[i] = 32'(3 * i);
    endtask

    // One dump from f to l; ready asserted with probability pct, optional stall
    // of stall_n cycles at the first word and a stray start at cycle mid_cyc.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                            input int stall_n, input int mid_cyc);
        logic [36:0] exp_q[$];
        logic [36:0] want;
        logic [36:0] prev_word;
        logic [4:0]  d;
        logic [4:0]  ix;
        logic [4:0]  addr_after_pair;
        int          n, cyc, k, stall_left;
        bit          prev_stall, finished;
        d = l - f;
        n = int'(d) + 1;
        for (int i = 0; i < n; i++) begin
            ix = 5'((int'(f) + i) % 32);
            exp_q.push_back({ix, (ix == 5'd0) ? 32'd0 : regs[ix]});
        end
        addr_after_pair = f + 5'd2;
        @(negedge clk);
        first_reg = f; last_reg = l; start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_rise: busy=%b expected 1", busy);
        end
        cyc = 1; k = 0; stall_left = stall_n; prev_stall = 0; finished = 0;
        while (cyc < 3000 && !finished) begin
            if (cyc == mid_cyc) begin
                start = 1'b1; first_reg = 5'd10; last_reg = 5'd12;
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.out_index, bus.out_data} !== prev_word) begin
                    errors++;
                    $display("FAIL hold: valid=%b idx/data=%h expected 1 / %h",
                             bus.out_valid, {bus.out_index, bus.out_data}, prev_word);
                end
            end
            if (bus.out_valid && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
                checks++;
                if (bus.rd_addr1 !== addr_after_pair || {bus.out_index, bus.out_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall: rd_addr1=%0d word=%h expected %0d / %h",
                             bus.rd_addr1, {bus.out_index, bus.out_data}, addr_after_pair, exp_q[0]);
                end
            end else begin
                bus.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            end
            checks++;
            if (busy !== 1'b1 || wr_block !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL status: busy=%b wr_block=%b done=%b expected 1 1 0 (cycle %0d)",
                         busy, wr_block, done, cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                want = exp_q.pop_front();
                checks++;
                if ({bus.out_index, bus.out_data} !== want) begin
                    errors++;
                    $display("FAIL word%0d: index=%0d data=%0d expected index=%0d data=%0d",
                             k, bus.out_index, bus.out_data, want[36:32], want[31:0]);
                end
                if (pct >= 100 && stall_n == 0) begin
                    checks++;
                    if (cyc != 2 + 3 * (k / 2) + (k % 2)) begin
                        errors++;
                        $display("FAIL timing%0d: handshake at cycle %0d expected %0d",
                                 k, cyc, 2 + 3 * (k / 2) + (k % 2));
                    end
                end
                k++;
                if (exp_q.size() == 0) finished = 1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_index, bus.out_data};
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_block !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b wr_block=%b valid=%b expected 1 0 0 0",
                     done, busy, wr_block, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_width: done=%b expected 0", done);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.out_valid, busy, wr_block, done} !== 4'b0 ||
            {bus.rd_addr1, bus.rd_addr2, bus.out_index} !== 15'd0 || bus.out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b wrb=%b done=%b a1=%0d a2=%0d idx=%0d data=%0d expected all 0",
                     bus.out_valid, busy, wr_block, done, bus.rd_addr1, bus.rd_addr2,
                     bus.out_index, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_dump();
        run_dump(5'd0, 5'd31, 100, 0, -1);
    endtask

    task automatic test_odd_range();
        run_dump(5'd5, 5'd7, 100, 0, -1);
    endtask

    task automatic test_wrap();
        run_dump(5'd30, 5'd1, 100, 0, -1);
    endtask

    task automatic test_backpressure();
        run_dump(5'd0, 5'd5, 100, 10, -1);
    endtask

    task automatic test_start_while_busy();
        run_dump(5'd0, 5'd7, 100, 0, 5);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start: busy=%b valid=%b done=%b expected 0 0 0",
                         busy, bus.out_valid, done);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int hsn, cyc;
        @(negedge clk);
        first_reg = 5'd0; last_reg = 5'd31; start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; hsn = 0; cyc = 0;
        while (hsn < 3 && cyc < 200) begin
            if (bus.out_valid && bus.out_ready) hsn++;
            if (hsn < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (hsn != 3) begin
            errors++; $display("FAIL mid_wait: %0d handshakes expected 3", hsn);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, busy, wr_block, done} !== 4'b0 ||
            {bus.rd_addr1, bus.rd_addr2, bus.out_index} !== 15'd0 || bus.out_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b done=%b a1=%0d a2=%0d idx=%0d data=%0d expected all 0",
                     bus.out_valid, busy, done, bus.rd_addr1, bus.rd_addr2, bus.out_index, bus.out_data);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_done: done=%b busy=%b expected 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        run_dump(5'd4, 5'd4, 100, 0, -1);
    endtask

    task automatic test_random();
        logic [4:0] f, l;
        for (int t = 0; t < 6; t++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            f = 5'($urandom_range(31));
            l = 5'($urandom_range(31));
            run_dump(f, l, int'($urandom_range(30, 100)), 0, -1);
        end
        fill_regs_linear();
    endtask

    initial begin
        fill_regs_linear();
        bus.out_ready = 1'b1;
        test_reset();
        test_full_dump();
        test_odd_range();
        test_wrap();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
